// File: rtl/stage_buf.sv
// -----------------------------------------------------------------------------
// stage_buf -- pipeline register between two stages of an in-order pipeline.
//
// Each clock edge the buffer does exactly one of these, highest priority first:
//   reset   (rst==0)           : NOP payload, dn_valid=0, loop_out=LOOP_INIT, RUN
//   flush   (flush==1)         : NOP payload, dn_valid=0, loop_out=LOOP_INIT, FLUSHED
//   capture (us==0)            : dn_* <= up_*, dn_valid=1, loop_out=LOOP_INIT, RUN
//   bubble  (us==1, ds==0)     : NOP payload, dn_valid=0, loop_out<=loop_in, BUBBLE
//   hold    (us==1, ds==1)     : dn_*/dn_valid kept, loop_out<=loop_in, HOLD
// where us = stall[STAGE_IDX] and ds = stall[STAGE_IDX+1] (0 for the last stage).
//
// Handshake: there is no valid/ready pair. The upstream stage is accepted on
// every edge where its own stall bit is clear; dn_valid marks whether the
// registered payload is a real instruction (1) or a bubble (0).
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   stall[STALL_W]           per-stage stall vector, 1 = stalled
//   flush                    discard buffered instruction and loopback state
//   up_wd/wreg/wdata/whilo/hi/lo   upstream result
//   dn_wd/wreg/wdata/whilo/hi/lo   registered result to downstream
//   dn_valid                 payload is a captured instruction
//   loop_in / loop_out       LOOP_CH channels of LOOP_W bits of loopback state
//   state                    current buffer state (RUN/BUBBLE/HOLD/FLUSHED)
//   stall_cnt                consecutive stalled edges
//
// Optional feature: define STAGE_BUF_STALL_CNT_EN to build the saturating
// stall counter; otherwise stall_cnt is tied to 0 and no counter exists.
// -----------------------------------------------------------------------------
module stage_buf #(
  parameter int                      DATA_W    = 32,
  parameter int                      ADDR_W    = 5,
  parameter int                      LOOP_CH   = 2,
  parameter int                      LOOP_W    = 64,
  parameter logic [LOOP_CH*LOOP_W-1:0] LOOP_INIT = '0,
  parameter int                      STALL_W   = 6,
  parameter int                      STAGE_IDX = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         up_wd,
  input  logic                      up_wreg,
  input  logic [DATA_W-1:0]         up_wdata,
  input  logic                      up_whilo,
  input  logic [DATA_W-1:0]         up_hi,
  input  logic [DATA_W-1:0]         up_lo,
  output logic [ADDR_W-1:0]         dn_wd,
  output logic                      dn_wreg,
  output logic [DATA_W-1:0]         dn_wdata,
  output logic                      dn_whilo,
  output logic [DATA_W-1:0]         dn_hi,
  output logic [DATA_W-1:0]         dn_lo,
  output logic                      dn_valid,
  input  logic [LOOP_CH*LOOP_W-1:0] loop_in,
  output logic [LOOP_CH*LOOP_W-1:0] loop_out,
  output logic [1:0]                state,
  output logic [15:0]               stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    BUBBLE  = 2'b01,
    HOLD    = 2'b10,
    FLUSHED = 2'b11
  } state_e;

  // The last stage has no downstream stall bit; index a valid bit anyway and
  // mask it so elaboration never reaches outside the vector.
  localparam bit HAS_DS = (STAGE_IDX < STALL_W - 1);
  localparam int DS_IDX = HAS_DS ? STAGE_IDX + 1 : STAGE_IDX;

  logic us;
  logic ds;
  assign us = stall[STAGE_IDX];
  assign ds = HAS_DS ? stall[DS_IDX] : 1'b0;

  // Other stages' stall bits are intentionally ignored here.
  logic unused_stall;
  assign unused_stall = ^stall;

  state_e state_q, state_d;

  // Next state ignores reset; reset is applied with top priority in the
  // sequential block.
  always_comb begin
    state_d = HOLD;
    if (flush)    state_d = FLUSHED;
    else if (!us) state_d = RUN;
    else if (!ds) state_d = BUBBLE;
    else          state_d = HOLD;
  end

  logic [ADDR_W-1:0]         wd_q;
  logic                      wreg_q;
  logic [DATA_W-1:0]         wdata_q;
  logic                      whilo_q;
  logic [DATA_W-1:0]         hi_q;
  logic [DATA_W-1:0]         lo_q;
  logic                      valid_q;
  logic [LOOP_CH*LOOP_W-1:0] loop_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
      loop_q  <= LOOP_INIT;
      state_q <= RUN;
    end else begin
      state_q <= state_d;
      unique case (state_d)
        RUN: begin
          wd_q    <= up_wd;
          wreg_q  <= up_wreg;
          wdata_q <= up_wdata;
          whilo_q <= up_whilo;
          hi_q    <= up_hi;
          lo_q    <= up_lo;
          valid_q <= 1'b1;
          loop_q  <= LOOP_INIT;
        end
        FLUSHED, BUBBLE: begin
          wd_q    <= '0;
          wreg_q  <= 1'b0;
          wdata_q <= '0;
          whilo_q <= 1'b0;
          hi_q    <= '0;
          lo_q    <= '0;
          valid_q <= 1'b0;
          // A flush discards loopback state; a bubble keeps the upstream
          // multi-cycle sequence alive by returning loop_in.
          loop_q  <= (state_d == FLUSHED) ? LOOP_INIT : loop_in;
        end
        HOLD: begin
          // Payload and dn_valid are held; only the loopback bank follows.
          loop_q  <= loop_in;
        end
        default: ;
      endcase
    end
  end

`ifdef STAGE_BUF_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (state_d == BUBBLE || state_d == HOLD) begin
      if (stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= '0;
    end
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

  assign dn_wd    = wd_q;
  assign dn_wreg  = wreg_q;
  assign dn_wdata = wdata_q;
  assign dn_whilo = whilo_q;
  assign dn_hi    = hi_q;
  assign dn_lo    = lo_q;
  assign dn_valid = valid_q;
  assign loop_out = loop_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_stage_buf -- directed self-checking bench for stage_buf (default params).
// Inputs change #1 after a rising edge; outputs are checked at the same point,
// i.e. after the edge they depend on has settled.
// -----------------------------------------------------------------------------
module tb_stage_buf;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic [4:0]   up_wd;
  logic         up_wreg;
  logic [31:0]  up_wdata;
  logic         up_whilo;
  logic [31:0]  up_hi;
  logic [31:0]  up_lo;
  logic [4:0]   dn_wd;
  logic         dn_wreg;
  logic [31:0]  dn_wdata;
  logic         dn_whilo;
  logic [31:0]  dn_hi;
  logic [31:0]  dn_lo;
  logic         dn_valid;
  logic [127:0] loop_in;
  logic [127:0] loop_out;
  logic [1:0]   state;
  logic [15:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

`ifdef STAGE_BUF_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  stage_buf dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .up_wd(up_wd), .up_wreg(up_wreg), .up_wdata(up_wdata),
    .up_whilo(up_whilo), .up_hi(up_hi), .up_lo(up_lo),
    .dn_wd(dn_wd), .dn_wreg(dn_wreg), .dn_wdata(dn_wdata),
    .dn_whilo(dn_whilo), .dn_hi(dn_hi), .dn_lo(dn_lo),
    .dn_valid(dn_valid), .loop_in(loop_in), .loop_out(loop_out),
    .state(state), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_nop(input string tag);
    check({tag, ".wd"},    128'(dn_wd),    128'd0);
    check({tag, ".wreg"},  128'(dn_wreg),  128'd0);
    check({tag, ".wdata"}, 128'(dn_wdata), 128'd0);
    check({tag, ".whilo"}, 128'(dn_whilo), 128'd0);
    check({tag, ".hi"},    128'(dn_hi),    128'd0);
    check({tag, ".lo"},    128'(dn_lo),    128'd0);
    check({tag, ".valid"}, 128'(dn_valid), 128'd0);
  endtask

  task automatic drive_up(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    up_wd = wd; up_wreg = wreg; up_wdata = wdata;
    up_whilo = whilo; up_hi = hi; up_lo = lo;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b1; stall = 6'b011000;
    loop_in = {64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002};
    drive_up(5'd9, 1'b1, 32'h1111_2222, 1'b1, 32'h3, 32'h4);

    // 1. reset dominates flush and stall
    step();
    check_nop("rst");
    check("rst.loop",  loop_out, 128'd0);
    check("rst.state", 128'(state), 128'd0);
    check("rst.cnt",   128'(stall_cnt), 128'd0);

    // 2. capture
    rst = 1'b1; flush = 1'b0; stall = 6'b000000; loop_in = 128'hFFFF;
    drive_up(5'd7, 1'b1, 32'hDEADBEEF, 1'b1, 32'h1111_1111, 32'h2222_2222);
    step();
    check("cap.wd",    128'(dn_wd),    128'd7);
    check("cap.wreg",  128'(dn_wreg),  128'd1);
    check("cap.wdata", 128'(dn_wdata), 128'hDEADBEEF);
    check("cap.whilo", 128'(dn_whilo), 128'd1);
    check("cap.hi",    128'(dn_hi),    128'h1111_1111);
    check("cap.lo",    128'(dn_lo),    128'h2222_2222);
    check("cap.valid", 128'(dn_valid), 128'd1);
    check("cap.loop",  loop_out, 128'd0);
    check("cap.state", 128'(state), 128'd0);

    // 3. bubble (us=1, ds=0)
    stall = 6'b001000; loop_in = 128'h1234;
    step();
    check_nop("bub");
    check("bub.loop",  loop_out, 128'h1234);
    check("bub.state", 128'(state), 128'd1);
    check("bub.cnt",   128'(stall_cnt), CNT_ON ? 128'd1 : 128'd0);

    // 4. hold after bubble keeps the NOP; channels move independently
    stall = 6'b011000;
    loop_in = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_0000_FFFF};
    drive_up(5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h9, 32'h8);
    step();
    check_nop("hold1");
    check("hold1.loop",  loop_out, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_0000_FFFF});
    check("hold1.state", 128'(state), 128'd2);
    check("hold1.cnt",   128'(stall_cnt), CNT_ON ? 128'd2 : 128'd0);

    // 5. bubble again
    stall = 6'b001000; loop_in = 128'h77;
    step();
    check_nop("bub2");
    check("bub2.state", 128'(state), 128'd1);
    check("bub2.cnt",   128'(stall_cnt), CNT_ON ? 128'd3 : 128'd0);

    // 6. clear stall -> capture, loop_out back to LOOP_INIT, counter clears
    stall = 6'b000000;
    drive_up(5'd3, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0);
    step();
    check("cap2.loop",  loop_out, 128'd0);
    check("cap2.wdata", 128'(dn_wdata), 128'hA5A5A5A5);
    check("cap2.state", 128'(state), 128'd0);
    check("cap2.cnt",   128'(stall_cnt), 128'd0);

    // 7. hold for 3 cycles with changing upstream data
    stall = 6'b011000; loop_in = 128'hABCD;
    drive_up(5'd0, 1'b0, 32'h0, 1'b1, 32'h5, 32'h6);
    for (int i = 0; i < 3; i++) step();
    check("hold3.wdata", 128'(dn_wdata), 128'hA5A5A5A5);
    check("hold3.wd",    128'(dn_wd),    128'd3);
    check("hold3.valid", 128'(dn_valid), 128'd1);
    check("hold3.loop",  loop_out, 128'hABCD);
    check("hold3.state", 128'(state), 128'd2);
    check("hold3.cnt",   128'(stall_cnt), CNT_ON ? 128'd3 : 128'd0);

    // 8. flush during hold
    flush = 1'b1;
    step();
    check_nop("flush");
    check("flush.loop",  loop_out, 128'd0);
    check("flush.state", 128'(state), 128'd3);
    check("flush.cnt",   128'(stall_cnt), 128'd0);

    // 9. only this stage's bit matters: other bits set, us=0 -> capture
    flush = 1'b0; stall = 6'b110111; loop_in = 128'h99;
    drive_up(5'd17, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h1, 32'h2);
    step();
    check("oth.wd",    128'(dn_wd),    128'd17);
    check("oth.valid", 128'(dn_valid), 128'd1);
    check("oth.loop",  loop_out, 128'd0);
    check("oth.state", 128'(state), 128'd0);

    // 10. long hold -> saturation (counter build only)
    stall = 6'b011000; loop_in = 128'h5A;
`ifdef STAGE_BUF_STALL_CNT_EN
    for (int i = 0; i < 70000; i++) step();
    check("sat.cnt", 128'(stall_cnt), 128'hFFFF);
`else
    for (int i = 0; i < 20; i++) step();
    check("hold20.cnt", 128'(stall_cnt), 128'd0);
`endif
    check("long.state", 128'(state), 128'd2);
    check("long.wdata", 128'(dn_wdata), 128'h0BAD_F00D);

    // 11. reset with flush mid-sequence discards loopback state
    rst = 1'b0; flush = 1'b1;
    step();
    check_nop("rst2");
    check("rst2.loop",  loop_out, 128'd0);
    check("rst2.state", 128'(state), 128'd0);
    check("rst2.cnt",   128'(stall_cnt), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
